serial_operand_transmitter: RTL and testbench
=============================================

SERIAL_OPERAND_TRANSMITTER -- requirements
Module: serial_operand_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-low reset that is asserted while 0.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a pair this cycle.
REQ-006 The block SHALL have ports in_a and in_b, inputs, WIDTH each, the parallel operands.
REQ-007 The block SHALL have port ser_start, output, 1, a one-cycle frame-start pulse; it is sized to drive a serial comparator's synchronous rst.
REQ-008 The block SHALL have port ser_valid, output, 1, meaning ser_a and ser_b carry a data bit.
REQ-009 The block SHALL have ports ser_a and ser_b, outputs, 1 each, the serial operand bits sent most significant bit first.
REQ-010 The block SHALL have port ser_last, output, 1, marking the least significant bit cycle.

Function
REQ-011 The block SHALL use the states IDLE, START and SHIFT.
REQ-012 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-013 On a transfer, the block SHALL capture in_a and in_b into internal shift registers.
REQ-014 in_ready SHALL be 1 in IDLE, 1 in the SHIFT cycle where ser_last=1, and 0 otherwise.
REQ-015 in_ready SHALL depend only on state, never on in_valid.
REQ-016 IDLE SHALL go to START on a transfer and stay in IDLE otherwise.
REQ-017 START SHALL last exactly one cycle, with ser_start=1, ser_valid=0, ser_a=0, ser_b=0 and ser_last=0, and SHALL then go to SHIFT.
REQ-018 SHIFT SHALL last exactly WIDTH cycles with ser_valid=1.
REQ-019 In SHIFT cycle k (k=0..WIDTH-1), ser_a and ser_b SHALL equal captured bit [WIDTH-1-k] of a and b.
REQ-020 ser_last SHALL be 1 only in SHIFT cycle k=WIDTH-1.
REQ-021 At the end of the last SHIFT cycle, the block SHALL go to START if a transfer occurs and to IDLE otherwise.
REQ-022 Back-to-back throughput SHALL be one pair per WIDTH+1 cycles, with no IDLE gap.
REQ-023 Latency SHALL be: transfer at edge N gives ser_start in cycle N+1, the MSB in cycle N+2, and ser_last in cycle N+1+WIDTH.
REQ-024 The bit counter SHALL be $clog2(WIDTH) bits wide, SHALL count down from WIDTH-1 to 0, and SHALL never wrap past 0 while in SHIFT.
REQ-025 in_a and in_b changing after a transfer SHALL NOT affect the frame in flight.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no capture and no state change; the offering side holds it.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from in_* to ser_*.

Reset
REQ-028 Asserting rst (0) SHALL immediately force: state IDLE, counter 0, shift registers 0, ser_start=0, ser_valid=0, ser_a=0, ser_b=0, ser_last=0, in_ready=1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no further ser_valid SHALL appear for that pair.
REQ-030 After rst deasserts, the first transfer SHALL be accepted on the first rising edge.

Structure
REQ-031 Package serial_tx_pkg SHALL hold the state enum typedef (IDLE, START, SHIFT) and the localparam for the default WIDTH.
REQ-032 A single sub-module serial_shift_reg (WIDTH-bit parallel-load, MSB-out shift register) SHALL be instantiated twice, once for a and once for b.
REQ-033 The counter and FSM SHALL live in the top module.

Verification
REQ-034 Single frame, WIDTH=8, in_a=8'hA5, in_b=8'h3C: ser_start one cycle, then ser_a = 1,0,1,0,0,1,0,1 and ser_b = 0,0,1,1,1,1,0,0, with ser_last on the 8th bit.
REQ-035 Back-to-back: in_valid held with pairs (8'h10,8'h10) then (8'h7F,8'h80): second ser_start in the cycle right after the first ser_last; 18 cycles total from first acceptance to second ser_last.
REQ-036 Comparator loopback: drive ser_start into a most-significant-first serial comparator's rst and ser_a/ser_b into its a/b; on ser_last, its outputs SHALL match the reference: (3,5)->less, (9,9)->eq, (200,13)->greater.
REQ-037 Stall: in_valid=1 during START and SHIFT cycles 0..6: no capture (in_ready=0); the pair is accepted only in the ser_last cycle.
REQ-038 Reset mid-frame: assert rst at SHIFT cycle 3, between clock edges: all ser_* go 0 at once, in_ready=1; after release, a new pair (8'hFF,8'h00) serializes correctly.
REQ-039 Input change: alter in_a/in_b every cycle after acceptance: the serial output matches only the captured values.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial operand transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_tx_pkg;

    // Default operand width in bits; legal widths are 2..32.
    localparam int DEFAULT_WIDTH = 8;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 32;

    // Frame sequencing: IDLE waits for a pair, START emits the frame-start
    // pulse, SHIFT streams WIDTH bit cycles most significant bit first.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } tx_state_e;

    // Bit-counter width for a given operand width (never below one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register presenting its MSB, shifting left each enabled cycle.
// Latency: load visible on msb the cycle after the load edge; one bit per shift edge.
// Backpressure: none; load takes priority over shift, the caller sequences both.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next contents: a new operand replaces the old one, otherwise move one bit toward the MSB.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    // Storage; cleared immediately by reset so an abandoned frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/serial_operand_transmitter.sv
// Serialises an operand pair MSB first behind a one-cycle frame-start pulse.
// Latency: accept at edge N -> ser_start in N+1, MSB in N+2, ser_last in N+1+WIDTH.
// Backpressure: in_ready high in IDLE and in the ser_last cycle only; offers otherwise ignored.
module serial_operand_transmitter
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_start,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic in_shift;
    logic last_bit;
    logic xfer;
    logic a_msb;
    logic b_msb;

    // Everything visible outside is decoded from registered state, so in_* never reaches ser_*.
    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (cnt_q == '0);
    assign in_ready = (state_q == IDLE) || last_bit;
    assign xfer     = in_valid && in_ready;

    assign ser_start = (state_q == START);
    assign ser_valid = in_shift;
    assign ser_last  = last_bit;
    // Data lines are held low outside SHIFT even though the MSB is already loaded in START.
    assign ser_a     = in_shift && a_msb;
    assign ser_b     = in_shift && b_msb;

    // Next state and bit counter; the counter only loads in START and stops at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = SHIFT;
                cnt_d   = CNT_TOP;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    // Back-to-back frames skip IDLE entirely.
                    state_d = xfer ? START : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset abandons any frame in flight at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand a: captured on acceptance, shifted once per bit cycle.
    serial_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_a (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (in_shift),
        .din   (in_a),
        .msb   (a_msb)
    );

    // Operand b: identical path to operand a.
    serial_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_b (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (in_shift),
        .din   (in_b),
        .msb   (b_msb)
    );

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Self-checking bench: per-cycle queue-based reference model plus vector table and corner sequences.
// Latency: n/a.
// Backpressure: offers are held by the bench until the model says they are accepted.
module tb_serial_operand_transmitter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_start;
    logic         ser_valid;
    logic         ser_a;
    logic         ser_b;
    logic         ser_last;

    serial_operand_transmitter #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_start (ser_start),
        .ser_valid (ser_valid),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_last  (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first serial comparator fed from the serial lines, cleared by ser_start.
    logic cmp_lt;
    logic cmp_gt;
    always @(posedge clk) begin
        if (ser_start) begin
            cmp_lt <= 1'b0;
            cmp_gt <= 1'b0;
        end else if (ser_valid && !cmp_lt && !cmp_gt) begin
            cmp_lt <= !ser_a && ser_b;
            cmp_gt <= ser_a && !ser_b;
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: queue of expected output words {start,valid,a,b,last}, one per cycle.
    // An empty queue means idle. Each accepted pair appends one start word and W bit words.
    logic [4:0] mq[$];

    function automatic logic model_ready();
        return (mq.size() == 0) || (mq.size() == 1 && mq[0][0]);
    endfunction

    function automatic void push_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        mq.push_back(5'b10000);
        for (int k = 0; k < W; k++) begin
            mq.push_back({1'b0, 1'b1, a[W-1-k], b[W-1-k], (k == W-1)});
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, let the rising edge act, sample at the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic x);
        logic [4:0] exp;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        x = v && model_ready();
        if (mq.size() > 0) mq.delete(0);
        if (x) push_frame(a, b);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp = (mq.size() > 0) ? mq[0] : 5'b00000;
        chk("ser_outputs", {27'b0, ser_start, ser_valid, ser_a, ser_b, ser_last}, {27'b0, exp});
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sa;   // expected ser_a bits, first bit on the left
        logic [W-1:0] sb;   // expected ser_b bits, first bit on the left
        logic [1:0]   cmp;  // {lt, gt}
    } vec_t;

    vec_t vecs[5];

    // Accept one pair from idle, then scramble the inputs every cycle while it serialises.
    task automatic run_vec(input int i);
        logic         x;
        logic [W-1:0] oa;
        logic [W-1:0] ob;
        int           nb;
        int           st;
        int           ls;
        int           acc;
        oa = '0;
        ob = '0;
        nb = 0;
        st = -1;
        ls = -1;
        cycle(1'b1, vecs[i].a, vecs[i].b, x);
        acc = cyc;
        chk("vec_accept", {31'b0, x}, 32'd1);
        if (ser_start) st = cyc;
        for (int n = 0; n < W + 1; n++) begin
            cycle(1'b0, W'($urandom), W'($urandom), x);
            if (ser_start) st = cyc;
            if (ser_valid) begin
                oa = {oa[W-2:0], ser_a};
                ob = {ob[W-2:0], ser_b};
                nb++;
            end
            if (ser_last) ls = cyc;
        end
        chk("vec_ser_a_bits", {24'b0, oa}, {24'b0, vecs[i].sa});
        chk("vec_ser_b_bits", {24'b0, ob}, {24'b0, vecs[i].sb});
        chk("vec_bit_count", nb, W);
        chk("vec_start_latency", st - acc, 0);
        chk("vec_last_latency", ls - acc, W);
        chk("vec_comparator", {30'b0, cmp_lt, cmp_gt}, {30'b0, vecs[i].cmp});
    endtask

    initial begin
        logic x;
        int   acc1;
        int   acc2;
        int   l1;
        int   l2;
        int   s2;
        bit   got2;

        vecs[0] = '{a: 8'hA5, b: 8'h3C, sa: 8'b10100101, sb: 8'b00111100, cmp: 2'b01};
        vecs[1] = '{a: 8'd3,   b: 8'd5,   sa: 8'b00000011, sb: 8'b00000101, cmp: 2'b10};
        vecs[2] = '{a: 8'd9,   b: 8'd9,   sa: 8'b00001001, sb: 8'b00001001, cmp: 2'b00};
        vecs[3] = '{a: 8'd200, b: 8'd13,  sa: 8'b11001000, sb: 8'b00001101, cmp: 2'b01};
        vecs[4] = '{a: 8'hFF,  b: 8'h00,  sa: 8'b11111111, sb: 8'b00000000, cmp: 2'b01};

        // Reset state before any clock edge.
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        #3;
        chk("reset_outputs", {27'b0, ser_start, ser_valid, ser_a, ser_b, ser_last}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors; the first one is offered on the first edge after reset release.
        for (int i = 0; i < 4; i++) run_vec(i);

        // Back-to-back with a held offer that stalls through START and SHIFT 0..6.
        acc1 = -1; acc2 = -1; l1 = -1; l2 = -1; s2 = -1; got2 = 1'b0;
        cycle(1'b1, 8'h10, 8'h10, x);
        acc1 = cyc;
        for (int n = 0; n < 3 * W && l2 < 0; n++) begin
            if (!got2) cycle(1'b1, 8'h7F, 8'h80, x);
            else       cycle(1'b0, 8'h00, 8'h00, x);
            if (x && !got2) begin
                got2 = 1'b1;
                acc2 = cyc;
            end
            if (ser_start && cyc != acc1) s2 = cyc;
            if (ser_last) begin
                if (l1 < 0) l1 = cyc;
                else        l2 = cyc;
            end
        end
        chk("b2b_second_accepted", {31'b0, got2}, 32'd1);
        chk("b2b_accept_in_last_cycle", acc2, l1 + 1);
        chk("b2b_start_after_last", s2, l1 + 1);
        chk("b2b_total_cycles", l2 - acc1 + 1, 2 * W + 2);

        // Reset between edges during SHIFT cycle 3.
        cycle(1'b1, 8'hC3, 8'h5A, x);
        for (int n = 0; n < 4; n++) cycle(1'b0, 8'h00, 8'h00, x);
        chk("pre_reset_in_shift", {31'b0, ser_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_outputs", {27'b0, ser_start, ser_valid, ser_a, ser_b, ser_last}, 32'd0);
        chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("held_reset_outputs", {27'b0, ser_start, ser_valid, ser_a, ser_b, ser_last}, 32'd0);
        rst = 1'b1;
        for (int n = 0; n < 2; n++) cycle(1'b0, 8'h00, 8'h00, x);
        run_vec(4);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), x);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
